// File: rtl/ro_counter_array_if.sv
// Control/result bundle for ro_counter_array.
// master: the requester (drives start/window/enables, receives results).
// slave:  the counter array itself.
interface ro_counter_array_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 32,
    parameter int WIN_W = 32
);
    logic                    start;
    logic [WIN_W-1:0]        window_cycles;
    logic [N_CH-1:0]         ch_en;
    logic                    busy;
    logic                    done;
    logic [N_CH*CNT_W-1:0]   count;
    logic [N_CH-1:0]         sat;

    modport master (
        output start, window_cycles, ch_en,
        input  busy, done, count, sat
    );

    modport slave (
        input  start, window_cycles, ch_en,
        output busy, done, count, sat
    );
endinterface

// File: rtl/ro_counter_array.sv
// Multi-channel ring-oscillator edge counter sharing one gate window.
// Optional feature macro: RO_CNT_SAT_EN (saturating counts + per-channel sat flag).
// Without it counts wrap and sat is tied low.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | waiting for start, results held
// S_MEASURE | gate open, enabled channels count detected rises
// S_DONE    | one-cycle done pulse, results final
module ro_counter_array #(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 32,
    parameter int WIN_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_ref,
    input  logic             rst,
    input  logic [N_CH-1:0]  ro_in,
    ro_counter_array_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_DONE} state_t;

    state_t                   state;
    logic [WIN_W-1:0]         tick;
    logic [N_CH-1:0]          en_q;
    logic [CNT_W-1:0]         cnt_q [N_CH];
    logic [SYNC_STAGES-1:0]   sync_q [N_CH];
    logic [N_CH-1:0]          rise;
    logic                     busy_q;
    logic                     done_q;
    logic [N_CH*CNT_W-1:0]    count_flat;
`ifdef RO_CNT_SAT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [N_CH-1:0]          sat_q;
`endif

    // Free-running synchronisers; stage 0 captures the raw oscillator.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) sync_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], ro_in[i]};
        end
    end

    // Rising edge seen between the last two synchroniser stages.
    always_comb begin
        rise = '0;
        for (int i = 0; i < N_CH; i++)
            rise[i] = sync_q[i][SYNC_STAGES-2] & ~sync_q[i][SYNC_STAGES-1];
    end

    // Sequencer, gate timer and per-channel counters with registered outputs.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            tick   <= '0;
            en_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
`ifdef RO_CNT_SAT_EN
            sat_q  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        tick <= bus.window_cycles;
                        en_q <= bus.ch_en;
                        for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
`ifdef RO_CNT_SAT_EN
                        sat_q <= '0;
`endif
                        // A zero-length window skips straight to the done pulse.
                        if (bus.window_cycles != '0) begin
                            state  <= S_MEASURE;
                            busy_q <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_MEASURE: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (en_q[i] && rise[i]) begin
`ifdef RO_CNT_SAT_EN
                            if (cnt_q[i] == CNT_MAX) sat_q[i] <= 1'b1;
                            else                     cnt_q[i] <= cnt_q[i] + CNT_W'(1);
`else
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
`endif
                        end
                    end
                    tick <= tick - WIN_W'(1);
                    if (tick == WIN_W'(1)) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Pack per-channel counts onto the flat result bus.
    always_comb begin
        count_flat = '0;
        for (int i = 0; i < N_CH; i++)
            count_flat[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.count = count_flat;
`ifdef RO_CNT_SAT_EN
    assign bus.sat   = sat_q;
`else
    assign bus.sat   = '0;
`endif
endmodule

// File: tb/tb_ro_counter_array.sv
// Directed bench for ro_counter_array: a 2-channel 32-bit instance plus a
// 1-channel 4-bit instance for overflow behaviour. Oscillators are driven
// synchronously at negedge so every expected count is exact.
module tb_ro_counter_array;
    logic        clk_ref = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] win;
    logic [1:0]  en;
    logic [1:0]  ro;

    int n_vec = 0;
    int n_err = 0;

    int          lat, ndone, nbusy;
    logic [31:0] dc0, dc1, ec0, ec1, pc0, zc0;
    logic [3:0]  dcs;
    logic        dss;
    logic [1:0]  dsat;

    always #5 clk_ref = ~clk_ref;

    ro_counter_array_if #(.N_CH(2), .CNT_W(32), .WIN_W(32)) bus ();
    ro_counter_array_if #(.N_CH(1), .CNT_W(4),  .WIN_W(16)) s_bus ();

    assign bus.start           = start;
    assign bus.window_cycles   = win;
    assign bus.ch_en           = en;
    assign s_bus.start         = start;
    assign s_bus.window_cycles = win[15:0];
    assign s_bus.ch_en         = en[0:0];

    ro_counter_array #(.N_CH(2), .CNT_W(32), .WIN_W(32), .SYNC_STAGES(2)) dut (
        .clk_ref (clk_ref),
        .rst     (rst),
        .ro_in   (ro),
        .bus     (bus)
    );

    ro_counter_array #(.N_CH(1), .CNT_W(4), .WIN_W(16), .SYNC_STAGES(2)) dut_s (
        .clk_ref (clk_ref),
        .rst     (rst),
        .ro_in   (ro[0:0]),
        .bus     (s_bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Oscillator level at step k: low for the first half of each period.
    function automatic logic rv(input int k, input int p, input int off);
        if (p == 0) return 1'b0;
        return ((k + off) % p) >= (p / 2);
    endfunction

    // One measurement: start at step 0, optional ignored restarts at ra/rb,
    // optional async reset at rst_at, bounded to w+10 steps.
    task automatic run(input int w, input logic [1:0] e, input int p0, input int p1,
                       input int off, input int rst_at, input int ra, input int rb,
                       input bit pre, input bit stop);
        int lim;
        lim   = w + 10;
        lat   = -1;
        ndone = 0;
        nbusy = 0;
        if (pre) begin
            @(negedge clk_ref);
            start = 1'b0;
            ro    = 2'b00;
        end
        for (int k = 0; k <= lim; k++) begin
            @(negedge clk_ref);
            if (k == 0) begin
                pc0 = bus.count[31:0];
            end else begin
                if (bus.done) begin
                    ndone++;
                    if (ndone == 1) begin
                        lat  = k;
                        dc0  = bus.count[31:0];
                        dc1  = bus.count[63:32];
                        dcs  = s_bus.count;
                        dss  = s_bus.sat[0];
                        dsat = bus.sat;
                    end
                end
                if (bus.busy) nbusy++;
                if (k == 1) zc0 = bus.count[31:0];
                ec0 = bus.count[31:0];
                ec1 = bus.count[63:32];
            end
            start = 1'b0;
            if (k == 0) begin
                start = 1'b1;
                win   = w;
                en    = e;
            end else if (k == ra || k == rb) begin
                start = 1'b1;
                win   = 5;
                en    = 2'b11;
            end
            ro[0] = rv(k, p0, off);
            ro[1] = rv(k, p1, off);
            if (rst_at != 0 && k == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy",  bus.busy,  0);
                chk("rst_done",  bus.done,  0);
                chk("rst_count", bus.count, 0);
                chk("rst_sat",   bus.sat,   0);
            end else begin
                rst = 1'b0;
            end
            if (stop && ndone > 0) break;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        win   = '0;
        en    = '0;
        ro    = '0;
        repeat (3) @(negedge clk_ref);
        chk("reset_busy",   bus.busy,    0);
        chk("reset_done",   bus.done,    0);
        chk("reset_count",  bus.count,   0);
        chk("reset_sat",    bus.sat,     0);
        chk("reset_scount", s_bus.count, 0);
        rst = 1'b0;

        // Two channels, periods 4 and 6, 100-cycle window.
        run(100, 2'b11, 4, 6, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("w100_lat",   lat,   101);
        chk("w100_ndone", ndone, 1);
        chk("w100_busy",  nbusy, 100);
        chk("w100_c0",    dc0,   25);
        chk("w100_c1",    dc1,   17);
        chk("w100_hold0", ec0,   25);
        chk("w100_hold1", ec1,   17);
        chk("w100_sat",   dsat,  0);

        // Zero-length window.
        run(0, 2'b11, 4, 6, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("w0_lat",   lat,   1);
        chk("w0_ndone", ndone, 1);
        chk("w0_busy",  nbusy, 0);
        chk("w0_c0",    dc0,   0);
        chk("w0_c1",    dc1,   0);

        // One-cycle window catching a single rise.
        run(1, 2'b01, 4, 0, 2, 0, 0, 0, 1'b1, 1'b0);
        chk("w1_lat",  lat,   2);
        chk("w1_busy", nbusy, 1);
        chk("w1_c0",   dc0,   1);

        // Channel 1 disabled; restarts in MEASURE and in DONE are ignored.
        run(64, 2'b01, 4, 6, 0, 0, 20, 65, 1'b1, 1'b0);
        chk("en01_lat",   lat,   65);
        chk("en01_ndone", ndone, 1);
        chk("en01_c0",    dc0,   16);
        chk("en01_c1",    dc1,   0);

        // 25 rises into a 4-bit counter.
        run(200, 2'b01, 8, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("ovf_wide_c0", dc0, 25);
`ifdef RO_CNT_SAT_EN
        chk("ovf_narrow_c", dcs, 15);
        chk("ovf_narrow_s", dss, 1);
`else
        chk("ovf_narrow_c", dcs, 9);
        chk("ovf_narrow_s", dss, 0);
`endif

        // Reset in the middle of a window.
        run(100, 2'b11, 4, 6, 0, 30, 0, 0, 1'b1, 1'b0);
        chk("rstm_ndone", ndone, 0);
        chk("rstm_busy",  nbusy, 30);
        chk("rstm_c0",    ec0,   0);

        run(10, 2'b11, 4, 6, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("w10_lat", lat, 11);
        chk("w10_c0",  dc0, 2);
        chk("w10_c1",  dc1, 2);

        // Back-to-back: second start at the earliest accepted cycle.
        run(20, 2'b11, 4, 6, 0, 0, 0, 0, 1'b1, 1'b1);
        chk("b2b1_lat", lat, 21);
        chk("b2b1_c0",  dc0, 5);
        chk("b2b1_c1",  dc1, 3);
        run(20, 2'b11, 4, 6, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("b2b2_held",  pc0,   5);
        chk("b2b2_clear", zc0,   0);
        chk("b2b2_lat",   lat,   21);
        chk("b2b2_ndone", ndone, 1);
        chk("b2b2_c0",    dc0,   5);
        chk("b2b2_c1",    dc1,   3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
